// File: rtl/bless_inj_arb_pkg.sv
// bless_inj_arb_pkg: flit widths, control valid-bit index and shared types for the BLESS injection arbiter
package bless_inj_arb_pkg;
  localparam int CONTROL_W = 22;
  localparam int DATA_W = 128;
  localparam int VALID_BIT = 21;
  typedef logic [CONTROL_W-1:0] control_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef struct packed {
    control_t c;
    data_t d;
  } flit_t;
  localparam int FLIT_W = $bits(flit_t);
  typedef enum logic {GNT_REQ, GNT_RSP} gnt_e;
endpackage

// File: rtl/bless_inj_arb_if.sv
// bless_inj_arb_if: requester handshakes and router injection port of the BLESS injection arbiter
interface bless_inj_arb_if;
  import bless_inj_arb_pkg::*;
  logic req_valid;
  logic req_ready;
  control_t req_c;
  data_t req_d;
  logic rsp_valid;
  logic rsp_ready;
  control_t rsp_c;
  data_t rsp_d;
  logic port4_ready;
  control_t inj_c;
  data_t inj_d;
  logic starve;
  modport master (
    output req_valid, req_c, req_d, rsp_valid, rsp_c, rsp_d, port4_ready,
    input req_ready, rsp_ready, inj_c, inj_d, starve
  );
  modport slave (
    input req_valid, req_c, req_d, rsp_valid, rsp_c, rsp_d, port4_ready,
    output req_ready, rsp_ready, inj_c, inj_d, starve
  );
endinterface

// File: rtl/bless_inj_fifo.sv
// bless_inj_fifo: per-requester flit FIFO with wrap-bit pointers
module bless_inj_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 150
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  assign full = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign empty = wp_q == rp_q;
  assign head = mem_q[rp_q[AW-1:0]];
  // write the pushed flit at the tail and advance both pointers independently
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q[AW-1:0]] = din;
    wp_d = wp_q + {{AW{1'b0}}, push};
    rp_d = rp_q + {{AW{1'b0}}, pop};
  end
  // pointers reset to empty; storage needs no reset since empty masks it
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // flit storage
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/bless_inj_arb.sv
// bless_inj_arb: round-robin request/reply injection into BLESS router port 4; BLESS_INJ_STARVE_EN adds the starvation counter
module bless_inj_arb
  import bless_inj_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 255
) (
  input logic clk,
  input logic rst,
  bless_inj_arb_if.slave bus
);
  logic req_full, req_empty, rsp_full, rsp_empty;
  logic req_push, rsp_push, req_pop, rsp_pop;
  logic pick_req, pick_rsp, stage_v, stage_free;
  flit_t req_head, rsp_head, stage_q, stage_d;
  gnt_e last_q, last_d;
  assign bus.req_ready = !req_full && rst;
  assign bus.rsp_ready = !rsp_full && rst;
  assign req_push = bus.req_valid && bus.req_ready && bus.req_c[VALID_BIT];
  assign rsp_push = bus.rsp_valid && bus.rsp_ready && bus.rsp_c[VALID_BIT];
  bless_inj_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_req_fifo (
    .clk(clk), .rst(rst), .push(req_push), .pop(req_pop),
    .din({bus.req_c, bus.req_d}), .full(req_full), .empty(req_empty), .head(req_head)
  );
  bless_inj_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(rsp_push), .pop(rsp_pop),
    .din({bus.rsp_c, bus.rsp_d}), .full(rsp_full), .empty(rsp_empty), .head(rsp_head)
  );
  assign stage_v = stage_q.c[VALID_BIT];
  assign stage_free = !stage_v || bus.port4_ready;
  assign bus.inj_c = stage_q.c;
  assign bus.inj_d = stage_q.d;
  // pick a winner when the stage frees up; ties go to whoever was not granted last
  always_comb begin
    pick_rsp = !rsp_empty && (req_empty || last_q == GNT_REQ);
    pick_req = !req_empty && !pick_rsp;
    req_pop = stage_free && pick_req;
    rsp_pop = stage_free && pick_rsp;
    stage_d = !stage_free ? stage_q : pick_rsp ? rsp_head : pick_req ? req_head : '0;
    last_d = req_pop ? GNT_REQ : rsp_pop ? GNT_RSP : last_q;
  end
  // injection stage and last-grant pointer; reset favours request on the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= '0;
      last_q <= GNT_RSP;
    end else begin
      stage_q <= stage_d;
      last_q <= last_d;
    end
  end
`ifdef BLESS_INJ_STARVE_EN
  logic [7:0] cnt_q, cnt_d;
  logic starve_q, starve_d;
  // count consecutive stalled cycles, saturating; any consumption clears it
  always_comb begin
    cnt_d = (stage_v && !bus.port4_ready) ? ((cnt_q == 8'(STARVE_LIMIT)) ? cnt_q : cnt_q + 8'd1) : 8'd0;
    starve_d = cnt_d == 8'(STARVE_LIMIT);
  end
  // starvation counter and registered flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      starve_q <= starve_d;
    end
  end
  assign bus.starve = starve_q;
`else
  assign bus.starve = 1'b0;
`endif
endmodule

// File: tb/tb_bless_inj_arb.sv
// tb_bless_inj_arb: directed stimulus with a scoreboard queue checked by a negedge monitor
module tb_bless_inj_arb;
  import bless_inj_arb_pkg::*;
`ifdef BLESS_INJ_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  flit_t exp_q[$];
  bless_inj_arb_if bif ();
  bless_inj_arb #(.DEPTH(4), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [149:0] act, input logic [149:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mk(input logic [7:0] tag);
    flit_t f;
    f.c = 22'h200000 | {14'd0, tag};
    f.d = {120'd0, tag};
    return f;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk("drain_left", 150'(exp_q.size()), 150'd0);
  endtask

  // every flit consumed by the router must be the next one the scoreboard expects
  always @(negedge clk) begin
    if (rst && bif.inj_c[VALID_BIT] && bif.port4_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_inj: got %h want none", bif.inj_c);
      end else begin
        chk("inj_flit", {bif.inj_c, bif.inj_d}, exp_q.pop_front());
      end
    end
  end

  initial begin
    bif.req_valid = 1'b1;
    bif.req_c = 22'h200802;
    bif.req_d = 128'h1;
    bif.rsp_valid = 1'b0;
    bif.rsp_c = '0;
    bif.rsp_d = '0;
    bif.port4_ready = 1'b1;
    tick();
    tick();
    chk("rst_inj_c", 150'(bif.inj_c), 150'd0);
    chk("rst_req_ready", 150'(bif.req_ready), 150'd0);
    chk("rst_starve", 150'(bif.starve), 150'd0);
    rst = 1'b1;
    bif.req_valid = 1'b0;
    #1;
    chk("rel_req_ready", 150'(bif.req_ready), 150'd1);
    chk("rel_rsp_ready", 150'(bif.rsp_ready), 150'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_nothing_queued", 150'(bif.inj_c), 150'd0);
    end
    bif.req_valid = 1'b1;
    bif.req_c = 22'h200802;
    bif.req_d = 128'h0123456789abcdef0123456789abcdef;
    exp_q.push_back({bif.req_c, bif.req_d});
    tick();
    bif.req_valid = 1'b0;
    chk("no_bypass", 150'(bif.inj_c), 150'd0);
    tick();
    chk("single_c", 150'(bif.inj_c), 150'h200802);
    chk("single_d", 150'(bif.inj_d), 150'h0123456789abcdef0123456789abcdef);
    tick();
    chk("single_bubble", 150'(bif.inj_c), 150'd0);
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      bif.req_valid = 1'b1;
      {bif.req_c, bif.req_d} = mk(8'(t));
      bif.rsp_valid = 1'b1;
      {bif.rsp_c, bif.rsp_d} = mk(8'(t + 4));
      exp_q.push_back(mk(8'(t)));
      exp_q.push_back(mk(8'(t + 4)));
      tick();
    end
    bif.req_valid = 1'b0;
    bif.rsp_valid = 1'b0;
    drain();
    bif.port4_ready = 1'b0;
    for (int t = 11; t <= 15; t++) begin
      chk("full_ready_pre", 150'(bif.req_ready), 150'd1);
      bif.req_valid = 1'b1;
      {bif.req_c, bif.req_d} = mk(8'(t));
      exp_q.push_back(mk(8'(t)));
      tick();
    end
    bif.req_valid = 1'b0;
    chk("full_ready_low", 150'(bif.req_ready), 150'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", {bif.inj_c, bif.inj_d}, mk(8'd11));
      tick();
    end
    bif.port4_ready = 1'b1;
    drain();
    chk("full_ready_back", 150'(bif.req_ready), 150'd1);
    bif.req_valid = 1'b1;
    bif.req_c = 22'h000802;
    bif.req_d = 128'hdead;
    tick();
    bif.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("invalid_dropped", 150'(bif.inj_c), 150'd0);
      tick();
    end
    bif.req_valid = 1'b1;
    {bif.req_c, bif.req_d} = mk(8'd20);
    exp_q.push_back(mk(8'd20));
    tick();
    bif.req_valid = 1'b0;
    chk("after_invalid_early", 150'(bif.inj_c), 150'd0);
    tick();
    chk("after_invalid_lat", 150'(bif.inj_c), 150'(mk(8'd20).c));
    tick();
    bif.port4_ready = 1'b0;
    bif.req_valid = 1'b1;
    {bif.req_c, bif.req_d} = mk(8'd30);
    exp_q.push_back(mk(8'd30));
    tick();
    bif.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("starve_below", 150'(bif.starve), 150'd0);
    end
    tick();
    chk("starve_set", 150'(bif.starve), 150'(STARVE_ON));
    chk("starve_hold_c", 150'(bif.inj_c), 150'(mk(8'd30).c));
    bif.port4_ready = 1'b1;
    tick();
    chk("starve_clear", 150'(bif.starve), 150'd0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bless_inj_arb.md
# bless_inj_arb

Injection arbiter for the BLESS router's local port (port 4). Two local requesters, a request queue and a reply queue, each buffer flits in a small FIFO. The block round-robins between them into a one-entry injection stage that drives `port4_ci`/`port4_di`. A flit leaves the stage only in a cycle where the router reports a free injection slot (`port4_ready`).

## Interface
- `DEPTH`, 4: entries per requester FIFO; power of two, ≥2.
- `STARVE_LIMIT`, 255: saturation value of the starvation counter (8-bit).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request flit offered.
- `req_ready`  out  1  request FIFO can accept.
- `req_c`  in  `control_w` (22)  request control word.
- `req_d`  in  `data_w` (128)  request data.
- `rsp_valid`, `rsp_ready`, `rsp_c`, `rsp_d`: the same four ports for the reply requester.
- `port4_ready`  in  1  router injection slot free this cycle.
- `inj_c`  out  `control_w`  to router `port4_ci`; bit 21 is the valid bit.
- `inj_d`  out  `data_w`  to router `port4_di`.
- `starve`  out  1  injection stalled for `STARVE_LIMIT` cycles.

## Operation
- **Push.** A requester pushes on `X_valid && X_ready`.
  - `X_ready` = not full and `rst` high. It does not depend on a same-cycle pop.
  - A pushed flit with control bit 21 clear is accepted but discarded. The FIFO is unchanged.
- **Stage.** `stage_v` equals `inj_c[21]`. The stage is free when `!stage_v || port4_ready`.
- **Arbitration.** The arbiter runs only when the stage is free.
  - If exactly one FIFO is non-empty, it wins.
  - If both are non-empty, the winner is the requester not granted last.
  - The winner's head is popped into the stage and the last-grant pointer is updated.
  - If neither FIFO is non-empty, the stage loads all-zero control and data.
- **Hold.** If the stage is occupied and `port4_ready` is low, the stage and both FIFOs' heads hold. `inj_c`/`inj_d` stay stable.
- **No bypass.** A push is never visible at `inj_*` in the same cycle.
- **FIFOs.** Pointers are `log2(DEPTH)+1` bits with wrap bit. Full means equal index with differing wrap bit. Empty means pointers equal. Pointers wrap modulo `2*DEPTH`.
- **Simultaneous events.** A push and a pop on the same FIFO in one cycle are both performed, and the count is unchanged. A push to a full FIFO cannot occur because ready is low.

## Timing
- **Reset.** While `rst` is low at a rising edge:
  - Both FIFOs empty, last-grant pointer set to reply (so request wins first tie), stage cleared, starvation counter 0.
  - `inj_c`=0, `inj_d`=0, `starve`=0, `req_ready`=`rsp_ready`=0.
- **Mid-operation reset.** Queued and staged flits are discarded. `inj_c` reads 0 after that edge.
- **Latency.** A push accepted at edge N, into an empty FIFO with the stage free, appears on `inj_*` after edge N+1. It is consumed at the first later edge with `port4_ready` high.
- **Throughput.** One flit per cycle while `port4_ready` stays high and a FIFO is non-empty.
- **Tie order.** Two simultaneously full queues alternate request, reply, request, …

## Configuration
- **`BLESS_INJ_STARVE_EN` defined:**
  - An 8-bit counter increments each cycle with `stage_v && !port4_ready`.
  - It saturates at `STARVE_LIMIT` and clears on any consumption or on reset.
  - `starve` = (counter == `STARVE_LIMIT`), registered, and falls the edge after consumption.
- **Undefined:** no counter exists and `starve` is tied 0.

## Structure
- **Shared package / defines:** `control_w`, `data_w` widths and the control valid-bit index (21), shared with `brouter`.
- **Sub-module:** `bless_inj_fifo` (parameterised `DEPTH`, push/pop/full/empty/head), instantiated twice.
- **Top level:** the arbiter, stage and starvation counter stay in `bless_inj_arb`.

## Test plan
1. **Reset.** Hold `rst`=0 for 2 cycles with `req_valid`=1 → `inj_c`=0, `req_ready`=0, nothing enqueued. Release → `req_ready`=1.
2. **Single flit.** Push `req_c`=22'h200802, `req_d`=128'h0123456789abcdef0123456789abcdef with `port4_ready`=1 → `inj_c`=22'h200802 one cycle later. `inj_c`=0 the cycle after.
3. **Tie.** Fill both FIFOs (request tags 1..4, reply tags 5..8) with `port4_ready`=1 → injected order 1,5,2,6,3,7,4,8.
4. **Full and stall.** With `port4_ready`=0, push 5 requests → `req_ready` drops after the 4th enqueue, with 1 more in the stage. `inj_c` holds the first flit unchanged. Raise ready → all 5 drain in order.
5. **Invalid push.** Push `req_c`=22'h000802 → never appears on `inj_c`, FIFO count unchanged.
6. **Starvation.** With `BLESS_INJ_STARVE_EN`, `STARVE_LIMIT`=4: stage valid and `port4_ready`=0 for 4 cycles → `starve`=1. One ready cycle → `starve`=0 next cycle. Built without the macro → `starve` stays 0.
